// File: rtl/saturn_bus_ctrl.sv
// saturn_bus_ctrl: serialises read/write/configure/bus-reset requests onto the Saturn nibble bus.
// Define SATURN_BUSCTRL_ADDR_CACHE_EN to keep a shadow DP and skip redundant LOAD_DP sequences.
module saturn_bus_ctrl #(
  parameter int RD_LAT = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clk_en,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [1:0]  i_req_op,
  input  logic [19:0] i_req_addr,
  input  logic [3:0]  i_req_len,
  input  logic [63:0] i_req_wdata,
  output logic [63:0] o_rd_data,
  output logic        o_done,
  output logic        o_bus_err,
  output logic        o_bus_clk_en,
  output logic        o_bus_is_data,
  output logic [3:0]  o_bus_nibble_out,
  input  logic [3:0]  i_bus_nibble_in,
  input  logic        i_bus_active
);

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_CFG   = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_LDCMD, S_ADDR, S_XCMD, S_DATA, S_DRAIN, S_DONE
  } state_t;

  state_t      r_state;
  logic [1:0]  r_op;
  logic [19:0] r_addr;
  logic [3:0]  r_len;
  logic [63:0] r_wdata;
  logic [3:0]  r_cnt;
  logic        r_err;
  logic [RD_LAT-1:0] r_capValid;
  logic [3:0]  r_capIdx [RD_LAT];

  logic        w_accept;
  logic        w_push;
  logic        w_capPending;
  logic        w_dataLast;
  logic        w_skipAddr;
  logic [3:0]  w_xcmd;
  logic [3:0]  w_dataNib;
  logic [31:0] w_addrPad;

  assign o_req_ready = (r_state == S_IDLE);
  assign w_accept    = i_req_valid && o_req_ready && i_clk_en;
  assign w_addrPad   = {12'h000, r_addr};
  assign w_dataLast  = (r_cnt == ((r_op == OP_CFG) ? 4'd4 : r_len));
  assign w_push      = i_clk_en && (r_state == S_DATA) && (r_op == OP_READ);

  always_comb begin
    w_xcmd    = 4'hF;
    w_dataNib = 4'h0;
    case (r_op)
      OP_READ:  w_xcmd = 4'h2;
      OP_WRITE: begin
        w_xcmd    = 4'h3;
        w_dataNib = r_wdata[{r_cnt, 2'b00} +: 4];
      end
      OP_CFG: begin
        w_xcmd    = 4'h6;
        w_dataNib = w_addrPad[{r_cnt[2:0], 2'b00} +: 4];
      end
      default: w_xcmd = 4'hF;
    endcase
  end

  // Only the final stage may still be in flight when DRAIN hands over to DONE.
  always_comb begin
    w_capPending = 1'b0;
    for (int s = 0; s < RD_LAT - 1; s++) begin
      w_capPending = w_capPending | r_capValid[s];
    end
  end

`ifdef SATURN_BUSCTRL_ADDR_CACHE_EN
  logic [19:0] r_shadow;
  logic        r_shadowValid;

  assign w_skipAddr = r_shadowValid && (i_req_addr == r_shadow);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_shadow      <= '0;
      r_shadowValid <= 1'b0;
    end else if (w_accept && i_req_op[1]) begin
      r_shadowValid <= 1'b0;
    end else if ((r_state == S_DONE) && i_clk_en && !r_op[1]) begin
      r_shadow      <= r_addr + 20'(r_len) + 20'd1;
      r_shadowValid <= 1'b1;
    end
  end
`else
  assign w_skipAddr = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_capValid <= '0;
      for (int s = 0; s < RD_LAT; s++) r_capIdx[s] <= '0;
    end else begin
      r_capValid[0] <= w_push;
      r_capIdx[0]   <= r_cnt;
      for (int s = 1; s < RD_LAT; s++) begin
        r_capValid[s] <= r_capValid[s-1];
        r_capIdx[s]   <= r_capIdx[s-1];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state          <= S_IDLE;
      r_op             <= '0;
      r_addr           <= '0;
      r_len            <= '0;
      r_wdata          <= '0;
      r_cnt            <= '0;
      r_err            <= 1'b0;
      o_rd_data        <= '0;
      o_done           <= 1'b0;
      o_bus_err        <= 1'b0;
      o_bus_clk_en     <= 1'b0;
      o_bus_is_data    <= 1'b0;
      o_bus_nibble_out <= '0;
    end else begin
      o_bus_clk_en <= 1'b0;
      o_done       <= 1'b0;
      o_bus_err    <= 1'b0;
      if (r_capValid[RD_LAT-1]) begin
        o_rd_data[{r_capIdx[RD_LAT-1], 2'b00} +: 4] <= i_bus_nibble_in;
        r_err <= r_err | ~i_bus_active;
      end
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op      <= i_req_op;
          r_addr    <= i_req_addr;
          r_len     <= i_req_len;
          r_wdata   <= i_req_wdata;
          r_cnt     <= '0;
          r_err     <= 1'b0;
          o_rd_data <= '0;
          if (i_req_op[1] || w_skipAddr) r_state <= S_XCMD;
          else                           r_state <= S_LDCMD;
        end
        S_LDCMD: if (i_clk_en) begin
          o_bus_clk_en     <= 1'b1;
          o_bus_is_data    <= 1'b0;
          o_bus_nibble_out <= 4'h5;
          r_cnt            <= '0;
          r_state          <= S_ADDR;
        end
        S_ADDR: if (i_clk_en) begin
          o_bus_clk_en     <= 1'b1;
          o_bus_is_data    <= 1'b1;
          o_bus_nibble_out <= w_addrPad[{r_cnt[2:0], 2'b00} +: 4];
          if (r_cnt == 4'd4) begin
            r_cnt   <= '0;
            r_state <= S_XCMD;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_XCMD: if (i_clk_en) begin
          o_bus_clk_en     <= 1'b1;
          o_bus_is_data    <= 1'b0;
          o_bus_nibble_out <= w_xcmd;
          r_cnt            <= '0;
          r_state          <= (r_op == 2'd3) ? S_DONE : S_DATA;
        end
        S_DATA: if (i_clk_en) begin
          o_bus_clk_en     <= 1'b1;
          o_bus_is_data    <= 1'b1;
          o_bus_nibble_out <= w_dataNib;
          if (w_dataLast) begin
            r_cnt   <= '0;
            r_state <= (r_op == OP_READ) ? S_DRAIN : S_DONE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_DRAIN: if (!w_capPending) r_state <= S_DONE;
        S_DONE: if (i_clk_en) begin
          o_done    <= 1'b1;
          o_bus_err <= r_err;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/saturn_bus_ctrl.md
# saturn_bus_ctrl

Bus-master sequencer for the Saturn nibble bus shared by the system RAM, ROM and I/O peripherals. It accepts one transaction at a time from the core: a read, a write, a configure, or a bus reset. It serialises each transaction into command, address and data nibbles, with one bus strobe per enabled clock. Read nibbles are captured back into a 64-bit word, and the transaction completes with a one-cycle done pulse.

## Interface
- RD_LAT, default 1: clocks from a read data strobe to the cycle in which `i_bus_nibble_in` is sampled; legal range 1..3.
- i_clk  in  1  clock.
- i_reset  in  1  reset; synchronous, active-high.
- i_clk_en  in  1  sequencer advance enable; at most one bus nibble per enabled cycle.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  high in IDLE; a request is accepted on valid&&ready&&i_clk_en.
- i_req_op  in  2  operation: 0 read, 1 write, 2 configure, 3 bus reset.
- i_req_addr  in  20  DP address for read/write; the configure value for configure.
- i_req_len  in  4  nibble count minus 1 (0 means 1 nibble, 15 means 16 nibbles).
- i_req_wdata  in  64  write data; nibble k is bits [4k+3:4k].
- o_rd_data  out  64  read data, same packing; valid from the o_done cycle until the next accept.
- o_done  out  1  one-cycle completion pulse.
- o_bus_err  out  1  valid with o_done: some read nibble was sampled while i_bus_active was 0.
- o_bus_clk_en  out  1  registered bus strobe, high one clock per nibble.
- o_bus_is_data  out  1  registered; 0 means the nibble is a command, 1 means address or data.
- o_bus_nibble_out  out  4  registered nibble driven to the bus.
- i_bus_nibble_in  in  4  OR of the peripheral read nibbles.
- i_bus_active  in  1  OR of the peripheral active flags.

## Operation
- Command codes: PC_READ 0, PC_WRITE 1, DP_READ 2, DP_WRITE 3, LOAD_PC 4, LOAD_DP 5, CONFIGURE 6, RESET F.
- State machine states: IDLE, LDCMD, ADDR, XCMD, DATA, DRAIN, DONE.
- IDLE: on accept, latch op/addr/len/wdata, clear o_rd_data and the error flag, then go to:
  - LDCMD for read or write;
  - XCMD for configure or reset.
- LDCMD: emit LOAD_DP (is_data=0) → ADDR.
- ADDR: emit 5 address nibbles, LSB first (is_data=1) → XCMD.
- XCMD: emit DP_READ, DP_WRITE, CONFIGURE or RESET, as selected by op.
  - read/write → DATA.
  - configure → DATA with an internal count of 5; the data nibbles are i_req_addr, LSB first.
  - reset → DONE.
- DATA: emit len+1 nibbles.
  - Write: drive wdata nibble k.
  - Read: drive 0.
  - After the last nibble → DRAIN for a read, DONE otherwise.
- DRAIN: wait until every read capture has landed (RD_LAT clocks after the last strobe) → DONE.
- Read capture: a delay line of RD_LAT stages carries (strobe && is_data && read-phase, index k).
  - When it emerges, write i_bus_nibble_in into o_rd_data nibble k.
  - In the same cycle, OR !i_bus_active into the error flag.
- DONE: pulse o_done and present o_bus_err → IDLE.
- Every state except DRAIN advances only on i_clk_en cycles. With i_clk_en=0 the state holds and o_bus_clk_en=0.
- Capture is not gated by i_clk_en.
- Reset output values: o_req_ready=1 (state IDLE); all of o_done, o_bus_err, o_bus_clk_en, o_bus_is_data, o_bus_nibble_out, o_rd_data are 0.
- Reset mid-transaction: the sequencer aborts to IDLE with no o_done. Pending captures are discarded.

## Timing
- Each emit state drives the registered bus outputs the clock after the state is entered on an enabled cycle.
- Strobe count per transaction:
  - read/write: 7+len+1 strobes;
  - configure: 6 strobes;
  - reset: 1 strobe.
- With i_clk_en=1 continuously:
  - write: accept to o_done = strobe count + 1 clocks;
  - read: accept to o_done = strobe count + RD_LAT + 1 clocks.
- o_req_ready falls the clock after accept and rises in the clock after o_done.

## Configuration
- SATURN_BUSCTRL_ADDR_CACHE_EN defined: the controller keeps a shadow DP (20-bit) plus a valid bit.
  - After read/write: shadow = addr+len+1, mod 2^20; valid=1.
  - Configure, bus-reset op and i_reset clear valid.
  - A read/write whose addr equals the valid shadow skips LDCMD/ADDR and goes directly to XCMD, saving 6 strobes.
- SATURN_BUSCTRL_ADDR_CACHE_EN undefined: LOAD_DP plus 5 address nibbles are always emitted, and no shadow logic exists.

## Test plan
- Write addr 80123, len 3, wdata 0x4321, i_clk_en=1 → strobes 5,3,2,1,0,8 (cmd then address) then 3,1,2,3,4; o_done 12 clocks after accept; o_bus_err=0.
- Read addr 80000, len 1, RD_LAT=1, bus returns A then 5 → o_rd_data=0x5A, o_bus_err=0; strobe count 9.
- Configure value 40000 → strobes 6(cmd),0,0,0,0,4 then o_done; bus-reset op → single strobe F then o_done.
- Read with i_bus_active=0 on the second nibble → o_bus_err=1 with o_done; i_clk_en toggling 1/0 → strobe only on enabled cycles and identical nibble sequence.
- With the macro: write 80000 len 1, then read 80002 → second transaction emits 2 then data strobes only (no LOAD_DP); read 80005 → full LOAD_DP sequence.
- i_reset asserted during ADDR → outputs at reset values next clock, no o_done, o_req_ready=1; the next request runs a full sequence.
